turn_controller: RTL

//  Game sequencer in front of board_ram. Owns the cursor (x,y), the side to move, and the detect/write/plot

---
 rtl/turn_controller_if.sv | 31 +++
 rtl/turn_controller.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/turn_controller_if.sv
// Bundle of key inputs, board_ram feedback and controller outputs for turn_controller.
// The master modport is the controller's view; the slave modport is the board / key side.
interface turn_controller_if;
   logic       key_place;
   logic       key_pass;
   logic       key_up;
   logic       key_down;
   logic       key_left;
   logic       key_right;
   logic [7:0] dir;
   logic [2:0] x;
   logic [2:0] y;
   logic       side;
   logic       detecten;
   logic       writeen;
   logic       en_plot;
   logic       busy;
   logic       illegal;
   logic [5:0] move_count;
   logic       game_over;

   modport master (
      input  key_place, key_pass, key_up, key_down, key_left, key_right, dir,
      output x, y, side, detecten, writeen, en_plot, busy, illegal, move_count, game_over
   );

   modport slave (
      output key_place, key_pass, key_up, key_down, key_left, key_right, dir,
      input  x, y, side, detecten, writeen, en_plot, busy, illegal, move_count, game_over
   );
endinterface

// File: rtl/turn_controller.sv
// Game sequencer in front of board_ram: cursor, side to move, detect/write/plot
// handshakes, pass tracking and game-over detection. One key action at a time.
module turn_controller #(
   parameter int DET_CYCLES  = 10,
   parameter int WR_CYCLES   = 10,
   parameter int PLOT_CYCLES = 1280000
) (
   input  logic              clock,
   input  logic              resetn,
   turn_controller_if.master bus
);

   localparam int MAX_A   = (DET_CYCLES > WR_CYCLES) ? DET_CYCLES : WR_CYCLES;
   localparam int MAX_CYC = (MAX_A > PLOT_CYCLES) ? MAX_A : PLOT_CYCLES;
   localparam int CNT_W   = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

   // Counters load N-1 and leave the state on the cycle they read zero.
   localparam logic [CNT_W-1:0] DET_LD  = CNT_W'(DET_CYCLES - 1);
   localparam logic [CNT_W-1:0] WR_LD   = CNT_W'(WR_CYCLES - 1);
   localparam logic [CNT_W-1:0] PLOT_LD = CNT_W'(PLOT_CYCLES - 1);
   localparam logic [5:0]       MAX_MOVES = 6'd60;

   typedef enum logic [2:0] {
      S_BOOT, S_IDLE, S_DETECT, S_EVAL, S_WRITE, S_SWAP, S_PLOT, S_OVER
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       x_q, x_d;
   logic [2:0]       y_q, y_d;
   logic             side_q, side_d;
   logic             illegal_q, illegal_d;
   logic [5:0]       mc_q, mc_d;
   logic             go_q, go_d;
   logic [1:0]       streak_q, streak_d;
   logic [7:0]       dir_l_q, dir_l_d;
   logic             det_q, det_d;
   logic             wr_q, wr_d;
   logic             plot_q, plot_d;
   logic [5:0]       key_prev_q;
   logic [5:0]       keys;
   logic [5:0]       key_edge;

   // Bit order sets nothing by itself; priority is resolved in the IDLE branch.
   assign keys     = {bus.key_right, bus.key_left, bus.key_down,
                      bus.key_up, bus.key_pass, bus.key_place};
   assign key_edge = keys & ~key_prev_q;

   // Next-state and datapath decisions for the turn sequence.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      x_d       = x_q;
      y_d       = y_q;
      side_d    = side_q;
      illegal_d = illegal_q;
      mc_d      = mc_q;
      streak_d  = streak_q;
      dir_l_d   = dir_l_q;
      case (state_q)
         S_BOOT: begin
            state_d = S_PLOT;
            cnt_d   = PLOT_LD;
         end
         S_IDLE: begin
            if (key_edge[0]) begin
               illegal_d = 1'b0;
               state_d   = S_DETECT;
               cnt_d     = DET_LD;
            end else if (key_edge[1]) begin
               side_d   = ~side_q;
               streak_d = streak_q + 2'd1;
               if (streak_q == 2'd1) begin
                  state_d = S_OVER;
               end else begin
                  state_d = S_PLOT;
                  cnt_d   = PLOT_LD;
               end
            end else if (key_edge[2]) begin
               y_d       = y_q - 3'd1;
               illegal_d = 1'b0;
            end else if (key_edge[3]) begin
               y_d       = y_q + 3'd1;
               illegal_d = 1'b0;
            end else if (key_edge[4]) begin
               x_d       = x_q - 3'd1;
               illegal_d = 1'b0;
            end else if (key_edge[5]) begin
               x_d       = x_q + 3'd1;
               illegal_d = 1'b0;
            end
         end
         S_DETECT: begin
            if (cnt_q == '0) begin
               dir_l_d = bus.dir;
               state_d = S_EVAL;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_EVAL: begin
            if (dir_l_q != 8'd0) begin
               state_d = S_WRITE;
               cnt_d   = WR_LD;
            end else begin
               illegal_d = 1'b1;
               state_d   = S_IDLE;
            end
         end
         S_WRITE: begin
            if (cnt_q == '0) begin
               state_d = S_SWAP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_SWAP: begin
            side_d   = ~side_q;
            streak_d = 2'd0;
            mc_d     = (mc_q >= MAX_MOVES) ? MAX_MOVES : mc_q + 6'd1;
            if (mc_q >= MAX_MOVES - 6'd1) begin
               state_d = S_OVER;
            end else begin
               state_d = S_PLOT;
               cnt_d   = PLOT_LD;
            end
         end
         S_PLOT: begin
            if (cnt_q == '0) begin
               state_d = go_q ? S_OVER : S_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_OVER: begin
            state_d = S_OVER;
         end
         default: begin
            state_d = S_BOOT;
         end
      endcase
   end

   // Request strobes are registered from the next state so they track it exactly.
   always_comb begin
      det_d  = (state_d == S_DETECT);
      wr_d   = (state_d == S_WRITE);
      plot_d = (state_d == S_PLOT);
      go_d   = go_q | (state_d == S_OVER);
   end

   // State and datapath registers; reset drops all requests immediately.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q    <= S_BOOT;
         cnt_q      <= '0;
         x_q        <= 3'd3;
         y_q        <= 3'd3;
         side_q     <= 1'b0;
         illegal_q  <= 1'b0;
         mc_q       <= 6'd0;
         go_q       <= 1'b0;
         streak_q   <= 2'd0;
         dir_l_q    <= 8'd0;
         det_q      <= 1'b0;
         wr_q       <= 1'b0;
         plot_q     <= 1'b0;
         key_prev_q <= 6'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         x_q        <= x_d;
         y_q        <= y_d;
         side_q     <= side_d;
         illegal_q  <= illegal_d;
         mc_q       <= mc_d;
         go_q       <= go_d;
         streak_q   <= streak_d;
         dir_l_q    <= dir_l_d;
         det_q      <= det_d;
         wr_q       <= wr_d;
         plot_q     <= plot_d;
         key_prev_q <= keys;
      end
   end

   assign bus.x          = x_q;
   assign bus.y          = y_q;
   assign bus.side       = side_q;
   assign bus.detecten   = det_q;
   assign bus.writeen    = wr_q;
   assign bus.en_plot    = plot_q;
   assign bus.busy       = (state_q != S_IDLE) && (state_q != S_OVER);
   assign bus.illegal    = illegal_q;
   assign bus.move_count = mc_q;
   assign bus.game_over  = go_q;

endmodule
